// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, reset PC, instruction width.
package cpu_pkg;

   localparam int          INST_W       = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0020;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_e;

   // Sign-extend a 16-bit branch offset to 32 bits.
   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC computation: pc + 4, plus the word-scaled signed branch offset when taken.
module pc_next (
   input  logic [31:0] pc,
   input  logic [15:0] imm16,
   input  logic        nPC_sel,
   output logic [31:0] npc
);
   import cpu_pkg::*;

   logic [31:0] seq_pc;
   logic [31:0] br_off;

   // Both adds wrap modulo 2^32; a negative offset is just a large unsigned add.
   assign seq_pc = pc + 32'd4;
   assign br_off = nPC_sel ? (sext16(imm16) << 2) : 32'd0;
   assign npc    = seq_pc + br_off;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, holds the
// returned word until decode accepts it, then advances the PC.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
   parameter int          IMEM_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              nPC_sel,
   input  logic [15:0]       imm16,
   output logic              imem_req,
   output logic [31:0]       imem_adr,
   input  logic              imem_valid,
   input  logic [INST_W-1:0] imem_data,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       pc,
   output logic              imem_err,
   output logic [31:0]       fetch_count
);

   localparam int            CW      = $clog2(IMEM_TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(IMEM_TIMEOUT - 1);

   fetch_state_e      state_q;
   logic [31:0]       pc_q;
   logic [INST_W-1:0] inst_q;
   logic              inst_valid_q;
   logic              imem_req_q;
   logic              imem_err_q;
   logic [31:0]       fetch_count_q;
   logic [CW-1:0]     wcnt_q;
   logic [31:0]       npc_d;

   pc_next u_pc_next (
      .pc      (pc_q),
      .imm16   (imm16),
      .nPC_sel (nPC_sel),
      .npc     (npc_d)
   );

   // Fetch FSM with registered outputs. imem_req_q is raised on every entry
   // to FETCH, so FETCH lasts one cycle; only the cycle straight out of reset
   // spends an extra FETCH cycle arming the request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC;
         inst_q        <= '0;
         inst_valid_q  <= 1'b0;
         imem_req_q    <= 1'b0;
         imem_err_q    <= 1'b0;
         fetch_count_q <= '0;
         wcnt_q        <= '0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (imem_req_q) begin
                  imem_req_q <= 1'b0;
                  wcnt_q     <= '0;
                  state_q    <= ST_WAIT;
               end else begin
                  imem_req_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (imem_valid) begin
                  inst_q       <= imem_data;
                  inst_valid_q <= 1'b1;
                  state_q      <= ST_HOLD;
               end else if (wcnt_q == TO_LAST) begin
                  // Memory went quiet: flag it and retry the same address.
                  imem_err_q <= 1'b1;
                  imem_req_q <= 1'b1;
                  wcnt_q     <= '0;
                  state_q    <= ST_FETCH;
               end else begin
                  wcnt_q <= wcnt_q + CW'(1);
               end
            end
            ST_HOLD: begin
               if (inst_ready) begin
                  pc_q          <= npc_d;
                  fetch_count_q <= fetch_count_q + 32'd1;
                  inst_valid_q  <= 1'b0;
                  imem_req_q    <= 1'b1;
                  state_q       <= ST_FETCH;
               end
            end
            default: state_q <= ST_FETCH;
         endcase
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_adr    = {pc_q[31:2], 2'b00};
   assign inst        = inst_q;
   assign inst_valid  = inst_valid_q;
   assign pc          = pc_q;
   assign imem_err    = imem_err_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run, all checked
// every cycle against a transaction-level model of the fetch protocol.
module tb_fetch_unit;

   localparam int          TO  = 16;
   localparam logic [31:0] RPC = 32'h0040_0020;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        nPC_sel = 1'b0;
   logic [15:0] imm16 = '0;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_data = '0;
   logic        inst_ready = 1'b0;
   logic        imem_req, inst_valid, imem_err;
   logic [31:0] imem_adr, inst, pc, fetch_count;

   logic        w_req, w_iv, w_err;
   logic [31:0] w_adr, w_inst, w_pc, w_cnt;

   int n_chk = 0;
   int n_fail = 0;

   // memory environment controls
   int          mem_lat = 1;   // 0 = never answer
   int          spur = 0;      // 0 none, 1 random, 2 every cycle
   bit          fix_en = 1'b1;
   logic [31:0] fix_data = 32'h2010_0005;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RPC), .IMEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .nPC_sel(nPC_sel), .imm16(imm16),
      .imem_req(imem_req), .imem_adr(imem_adr), .imem_valid(imem_valid),
      .imem_data(imem_data), .inst(inst), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .pc(pc), .imem_err(imem_err),
      .fetch_count(fetch_count)
   );

   // Second instance parked at the top of the address space to exercise wrap.
   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .IMEM_TIMEOUT(TO)) u_wrap (
      .clk(clk), .reset(reset), .nPC_sel(1'b0), .imm16(16'h0000),
      .imem_req(w_req), .imem_adr(w_adr), .imem_valid(1'b1),
      .imem_data(32'hDEAD_BEEF), .inst(w_inst), .inst_valid(w_iv),
      .inst_ready(1'b1), .pc(w_pc), .imem_err(w_err), .fetch_count(w_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc = RPC, m_inst = '0, m_cnt = '0;
   bit          m_have = 1'b0, m_req = 1'b0, m_busy = 1'b0, m_err = 1'b0, m_fresh = 1'b1;
   int          m_age = 0;
   bit          chk_en = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_pc <= RPC; m_inst <= '0; m_cnt <= '0; m_have <= 1'b0; m_req <= 1'b0;
         m_busy <= 1'b0; m_err <= 1'b0; m_fresh <= 1'b1; m_age <= 0; chk_en <= 1'b1;
      end else if (m_fresh) begin
         m_fresh <= 1'b0; m_req <= 1'b1;
      end else if (m_req) begin
         m_req <= 1'b0; m_busy <= 1'b1; m_age <= 0;
      end else if (m_busy) begin
         if (imem_valid) begin
            m_inst <= imem_data; m_have <= 1'b1; m_busy <= 1'b0;
         end else if (m_age + 1 == TO) begin
            m_err <= 1'b1; m_busy <= 1'b0; m_req <= 1'b1;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (m_have && inst_ready) begin
         m_pc   <= m_pc + 32'd4 + (nPC_sel ? 32'(signed'(imm16)) * 32'd4 : 32'd0);
         m_cnt  <= m_cnt + 32'd1;
         m_have <= 1'b0;
         m_req  <= 1'b1;
      end
   end

   // compare every cycle, mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_imem_req", imem_req, m_req);
         chk("m_imem_adr", imem_adr, {m_pc[31:2], 2'b00});
         chk("m_inst_valid", inst_valid, m_have);
         chk("m_inst", inst, m_inst);
         chk("m_pc", pc, m_pc);
         chk("m_imem_err", imem_err, m_err);
         chk("m_fetch_count", fetch_count, m_cnt);
      end
   end

   // ---------------- instruction memory ----------------
   int cd = -1;
   always @(negedge clk) begin
      logic v;
      v = 1'b0;
      if (reset) cd = -1;
      else begin
         if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin v = 1'b1; cd = -1; end
         end
         if (imem_req) cd = (mem_lat > 0) ? mem_lat : -1;
      end
      imem_valid = v | (spur == 2) | (spur == 1 && $urandom_range(0, 3) == 0);
      imem_data  = fix_en ? fix_data : $urandom;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_hold(input string nm);
      int n;
      n = 0;
      while (inst_valid !== 1'b1 && n < 30) begin tick(); n++; end
      chk(nm, inst_valid, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int gap;
      bit got;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;                                   // cycle 0
      tick();                                         // cycle 1: request
      chk("c1_req", imem_req, 1'b1);
      chk("c1_adr", imem_adr, 32'h0040_0020);
      chk("w_c1_req", w_req, 1'b1);
      chk("w_c1_adr", w_adr, 32'hFFFF_FFFC);
      tick();                                         // cycle 2: waiting
      chk("c2_req", imem_req, 1'b0);
      chk("c2_ivalid", inst_valid, 1'b0);
      tick();                                         // cycle 3: holding
      chk("c3_ivalid", inst_valid, 1'b1);
      chk("c3_inst", inst, 32'h2010_0005);
      chk("c3_pc", pc, 32'h0040_0020);
      chk("w_c3_inst", w_inst, 32'hDEAD_BEEF);
      chk("w_c3_ivalid", w_iv, 1'b1);
      nPC_sel = 1'b0; inst_ready = 1'b1;
      tick();                                         // cycle 4: sequential fetch
      chk("seq_adr", imem_adr, 32'h0040_0024);
      chk("seq_req", imem_req, 1'b1);
      chk("seq_cnt", fetch_count, 32'd1);
      chk("wrap_pc", w_pc, 32'h0000_0000);
      chk("wrap_adr", w_adr, 32'h0000_0000);
      chk("wrap_cnt", w_cnt, 32'd1);
      chk("wrap_err", w_err, 1'b0);
      inst_ready = 1'b0;
      fix_data = 32'h1234_5678;
      wait_hold("hold1_reached");
      chk("hold1_inst", inst, 32'h1234_5678);
      spur = 2; fix_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_inst", inst, 32'h1234_5678);
         chk("stall_req", imem_req, 1'b0);
         chk("stall_cnt", fetch_count, 32'd1);
         chk("stall_ivalid", inst_valid, 1'b1);
      end
      spur = 0; fix_en = 1'b1;
      inst_ready = 1'b1;
      tick();
      chk("seq2_adr", imem_adr, 32'h0040_0028);
      inst_ready = 1'b0;
      wait_hold("hold2_reached");
      nPC_sel = 1'b1; imm16 = 16'hFFFE; inst_ready = 1'b1;
      tick();
      chk("brneg_adr", imem_adr, 32'h0040_0024);
      chk("brneg_cnt", fetch_count, 32'd3);
      inst_ready = 1'b0; nPC_sel = 1'b0;
      tick();                                         // now waiting
      chk("pre_rst_wait", imem_req, 1'b0);
      reset = 1'b1;
      tick();
      chk("rst_req", imem_req, 1'b0);
      chk("rst_ivalid", inst_valid, 1'b0);
      chk("rst_pc", pc, RPC);
      chk("rst_cnt", fetch_count, 32'd0);
      chk("rst_err", imem_err, 1'b0);
      chk("rst_inst", inst, 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      fix_data = 32'hCAFE_0001;
      wait_hold("hold3_reached");
      nPC_sel = 1'b1; imm16 = 16'h0003; inst_ready = 1'b1; mem_lat = 0;
      tick();
      chk("brpos_adr", imem_adr, 32'h0040_0030);
      inst_ready = 1'b0; nPC_sel = 1'b0;
      gap = 0; got = 1'b0;
      for (int i = 1; i <= 40 && !got; i++) begin
         tick();
         if (i == 10) mem_lat = 2;
         if (imem_req === 1'b1) begin gap = i; got = 1'b1; end
      end
      chk("to_gap", gap, 32'd17);
      chk("to_adr", imem_adr, 32'h0040_0030);
      chk("to_err", imem_err, 1'b1);
      wait_hold("to_hold_reached");
      chk("to_inst", inst, 32'hCAFE_0001);
      chk("to_err_sticky", imem_err, 1'b1);
      chk("to_pc", pc, 32'h0040_0030);

      // randomized run, checked by the model
      spur = 1; fix_en = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         inst_ready = 1'($urandom_range(0, 1));
         nPC_sel    = 1'($urandom_range(0, 1));
         imm16      = 16'($urandom);
         mem_lat    = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 4));
         if ($urandom_range(0, 399) == 0) begin
            reset = 1'b1;
            repeat (3) tick();
            reset = 1'b0;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
